// File: rtl/ahb_master_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ahb_master_cmd_fifo
//
// Command FIFO between the user command port and the AHB master
// address-phase engine. Each entry carries one command: write flag,
// HBURST type, HSIZE and start address. The depth is configurable. The read
// side works either as first-word-fall-through or as a registered read with
// one cycle of latency. The FIFO reports its occupancy and an almost-full
// flag, and it keeps sticky overflow and underflow error flags.
//
// Ports:
//   i_clk                    clock, all logic on the rising edge
//   i_rstn                   synchronous active-low reset
//   i_wfifo_en               push strobe
//   i_wfifo_write            command direction, 1 = write
//   i_wfifo_user_burst_type  HBURST encoding
//   i_wfifo_user_size        HSIZE encoding
//   i_wfifo_user_addr        start address
//   i_rfifo_en               pop strobe
//   i_err_clr                clears the sticky error flags
//   o_rfifo_write            head/read command direction
//   o_rfifo_user_burst_type  head/read HBURST
//   o_rfifo_user_size        head/read HSIZE
//   o_rfifo_user_addr        head/read address
//   o_rfifo_valid            read data valid
//   o_fifo_full              occupancy equals the depth
//   o_fifo_empty             occupancy is zero
//   o_fifo_afull             occupancy >= AFULL_LEVEL
//   o_fifo_count             current occupancy
//   o_ovf_err                sticky: push while full without a same-cycle pop
//   o_udf_err                sticky: pop while empty
// ---------------------------------------------------------------------------
module ahb_master_cmd_fifo #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 2,
  parameter int AFULL_LEVEL = 3,
  parameter int FWFT        = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_wfifo_en,
  input  logic                  i_wfifo_write,
  input  logic [2:0]            i_wfifo_user_burst_type,
  input  logic [2:0]            i_wfifo_user_size,
  input  logic [ADDR_WIDTH-1:0] i_wfifo_user_addr,
  input  logic                  i_rfifo_en,
  input  logic                  i_err_clr,
  output logic                  o_rfifo_write,
  output logic [2:0]            o_rfifo_user_burst_type,
  output logic [2:0]            o_rfifo_user_size,
  output logic [ADDR_WIDTH-1:0] o_rfifo_user_addr,
  output logic                  o_rfifo_valid,
  output logic                  o_fifo_full,
  output logic                  o_fifo_empty,
  output logic                  o_fifo_afull,
  output logic [DEPTH_LOG2:0]   o_fifo_count,
  output logic                  o_ovf_err,
  output logic                  o_udf_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = ADDR_WIDTH + 7;

  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_n;
  logic [PW-1:0] rd_ptr_n;
  logic [PW-1:0] count;
  logic [PW-1:0] count_n;
  logic          full_q;
  logic          empty_q;
  logic          afull_q;
  logic          ovf_q;
  logic          udf_q;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_evt;
  logic          udf_evt;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;
  logic [EW-1:0] rd_entry;
  logic          rd_valid;

  assign wr_entry   = {i_wfifo_write, i_wfifo_user_burst_type,
                       i_wfifo_user_size, i_wfifo_user_addr};
  assign head_entry = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Handshake decode. A pop needs stored data, so an empty FIFO never
  // bypasses the input straight to the output. A push into a full FIFO is
  // still accepted when a pop frees a slot on the same edge.
  always_comb begin
    pop_ok   = i_rfifo_en & ~empty_q;
    push_ok  = i_wfifo_en & (~full_q | pop_ok);
    ovf_evt  = i_wfifo_en & full_q & ~pop_ok;
    udf_evt  = i_rfifo_en & empty_q;
    wr_ptr_n = push_ok ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_n = pop_ok  ? rd_ptr + PW'(1) : rd_ptr;
    count_n  = count;
    case ({push_ok, pop_ok})
      2'b10:   count_n = count + PW'(1);
      2'b01:   count_n = count - PW'(1);
      default: count_n = count;
    endcase
  end

  // Pointers, occupancy and the registered status flags. Full and empty
  // come from the next-state pointers: full when the slot indices match and
  // the wrap bits differ, empty when the pointers are identical. This keeps
  // every status flag aligned with the count on the same edge. An error
  // event in the same cycle as a clear wins, so no error is lost.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count   <= count_n;
      full_q  <= (wr_ptr_n[DEPTH_LOG2-1:0] == rd_ptr_n[DEPTH_LOG2-1:0]) &&
                 (wr_ptr_n[DEPTH_LOG2] != rd_ptr_n[DEPTH_LOG2]);
      empty_q <= (wr_ptr_n == rd_ptr_n);
      afull_q <= (count_n >= PW'(AFULL_LEVEL));
      ovf_q   <= (ovf_q & ~i_err_clr) | ovf_evt;
      udf_q   <= (udf_q & ~i_err_clr) | udf_evt;
    end
  end

  // The storage array has no reset, which keeps it cheap RAM-style storage.
  // Stale contents never reach the outputs because the read path is either
  // masked while the FIFO is empty or only loaded on an accepted pop.
  always_ff @(posedge i_clk) begin
    if (i_rstn && push_ok) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_entry;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_entry = empty_q ? '0 : head_entry;
      assign rd_valid = ~empty_q;
    end else begin : g_registered
      logic [EW-1:0] rd_q;
      logic          valid_q;

      // Registered read. The head entry is captured on the pop edge and held
      // until the next accepted pop. Valid is high only for the cycle that
      // follows an accepted pop.
      always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
          rd_q    <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= pop_ok;
          if (pop_ok) begin
            rd_q <= head_entry;
          end
        end
      end

      assign rd_entry = rd_q;
      assign rd_valid = valid_q;
    end
  endgenerate

  assign {o_rfifo_write, o_rfifo_user_burst_type,
          o_rfifo_user_size, o_rfifo_user_addr} = rd_entry;
  assign o_rfifo_valid = rd_valid;
  assign o_fifo_full   = full_q;
  assign o_fifo_empty  = empty_q;
  assign o_fifo_afull  = afull_q;
  assign o_fifo_count  = count;
  assign o_ovf_err     = ovf_q;
  assign o_udf_err     = udf_q;

endmodule

// File: tb/tb_ahb_master_cmd_fifo.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_cmd_fifo
//
// Directed bench for ahb_master_cmd_fifo. The bench drives two instances
// from the same stimulus:
//   dut_a  first-word-fall-through, 4 entries, almost-full at 3
//   dut_b  registered read, 8 entries, almost-full at 6
// Each step is applied and then the outputs are sampled 1 ns after the
// rising edge. Every expected value below was computed by hand.
// ---------------------------------------------------------------------------
module tb_ahb_master_cmd_fifo;

  logic        clk;
  logic        rstn;
  logic        wen;
  logic        wwrite;
  logic [2:0]  wburst;
  logic [2:0]  wsize;
  logic [31:0] waddr;
  logic        ren;
  logic        clr;

  logic        a_write, a_valid, a_full, a_empty, a_afull, a_ovf, a_udf;
  logic [2:0]  a_burst, a_size;
  logic [31:0] a_addr;
  logic [2:0]  a_count;

  logic        b_write, b_valid, b_full, b_empty, b_afull, b_ovf, b_udf;
  logic [2:0]  b_burst, b_size;
  logic [31:0] b_addr;
  logic [3:0]  b_count;

  int checks;
  int errors;

  ahb_master_cmd_fifo #(
    .ADDR_WIDTH(32), .DEPTH_LOG2(2), .AFULL_LEVEL(3), .FWFT(1)
  ) dut_a (
    .i_clk(clk), .i_rstn(rstn),
    .i_wfifo_en(wen), .i_wfifo_write(wwrite),
    .i_wfifo_user_burst_type(wburst), .i_wfifo_user_size(wsize),
    .i_wfifo_user_addr(waddr), .i_rfifo_en(ren), .i_err_clr(clr),
    .o_rfifo_write(a_write), .o_rfifo_user_burst_type(a_burst),
    .o_rfifo_user_size(a_size), .o_rfifo_user_addr(a_addr),
    .o_rfifo_valid(a_valid), .o_fifo_full(a_full), .o_fifo_empty(a_empty),
    .o_fifo_afull(a_afull), .o_fifo_count(a_count),
    .o_ovf_err(a_ovf), .o_udf_err(a_udf)
  );

  ahb_master_cmd_fifo #(
    .ADDR_WIDTH(32), .DEPTH_LOG2(3), .AFULL_LEVEL(6), .FWFT(0)
  ) dut_b (
    .i_clk(clk), .i_rstn(rstn),
    .i_wfifo_en(wen), .i_wfifo_write(wwrite),
    .i_wfifo_user_burst_type(wburst), .i_wfifo_user_size(wsize),
    .i_wfifo_user_addr(waddr), .i_rfifo_en(ren), .i_err_clr(clr),
    .o_rfifo_write(b_write), .o_rfifo_user_burst_type(b_burst),
    .o_rfifo_user_size(b_size), .o_rfifo_user_addr(b_addr),
    .o_rfifo_valid(b_valid), .o_fifo_full(b_full), .o_fifo_empty(b_empty),
    .o_fifo_afull(b_afull), .o_fifo_count(b_count),
    .o_ovf_err(b_ovf), .o_udf_err(b_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of push/pop/clear, wait for the edge, then return the
  // strobes to idle 1 ns later so that the caller can sample the result.
  task automatic applyStimulus(input logic w_en, input logic w_write,
                               input logic [2:0] burst, input logic [31:0] addr,
                               input logic r_en, input logic e_clr);
    wen    = w_en;
    wwrite = w_write;
    wburst = burst;
    wsize  = 3'b010;
    waddr  = addr;
    ren    = r_en;
    clr    = e_clr;
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
    clr = 1'b0;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    wen    = 1'b0;
    wwrite = 1'b0;
    wburst = 3'b000;
    wsize  = 3'b000;
    waddr  = '0;
    ren    = 1'b0;
    clr    = 1'b0;

    // Reset state.
    doReset();
    checkOutput("rst_count", 32'(a_count), 0);
    checkOutput("rst_empty", 32'(a_empty), 1);
    checkOutput("rst_full",  32'(a_full), 0);
    checkOutput("rst_afull", 32'(a_afull), 0);
    checkOutput("rst_valid", 32'(a_valid), 0);
    checkOutput("rst_ovf",   32'(a_ovf), 0);
    checkOutput("rst_udf",   32'(a_udf), 0);
    checkOutput("rst_addr",  a_addr, 0);

    // Fill four commands. The head falls through after the first push.
    applyStimulus(1, 1, 3'b011, 32'h100, 0, 0);
    checkOutput("fill1_count", 32'(a_count), 1);
    checkOutput("fill1_valid", 32'(a_valid), 1);
    checkOutput("fill1_head",  a_addr, 32'h100);
    checkOutput("fill1_afull", 32'(a_afull), 0);
    applyStimulus(1, 1, 3'b011, 32'h200, 0, 0);
    checkOutput("fill2_count", 32'(a_count), 2);
    checkOutput("fill2_afull", 32'(a_afull), 0);
    applyStimulus(1, 1, 3'b011, 32'h300, 0, 0);
    checkOutput("fill3_count", 32'(a_count), 3);
    checkOutput("fill3_afull", 32'(a_afull), 1);
    checkOutput("fill3_full",  32'(a_full), 0);
    applyStimulus(1, 1, 3'b011, 32'h400, 0, 0);
    checkOutput("fill4_count", 32'(a_count), 4);
    checkOutput("fill4_full",  32'(a_full), 1);
    checkOutput("fill4_head",  a_addr, 32'h100);
    checkOutput("fill4_write", 32'(a_write), 1);
    checkOutput("fill4_burst", 32'(a_burst), 3);
    checkOutput("fill4_size",  32'(a_size), 2);

    // Overflow: the push is dropped and the error is latched.
    applyStimulus(1, 1, 3'b011, 32'h500, 0, 0);
    checkOutput("ovf_flag",  32'(a_ovf), 1);
    checkOutput("ovf_count", 32'(a_count), 4);
    checkOutput("ovf_head",  a_addr, 32'h100);
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain1_head", a_addr, 32'(k + 1) * 32'h100);
      applyStimulus(0, 0, 3'b000, 0, 1, 0);
    end
    checkOutput("drain1_empty", 32'(a_empty), 1);
    checkOutput("drain1_count", 32'(a_count), 0);
    checkOutput("drain1_valid", 32'(a_valid), 0);
    checkOutput("drain1_ovf",   32'(a_ovf), 1);
    applyStimulus(0, 0, 3'b000, 0, 0, 1);
    checkOutput("clr_ovf", 32'(a_ovf), 0);

    // Push and pop together on a full FIFO. The write pointer wraps here.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 3'b011, 32'(k + 1) * 32'h100, 0, 0);
    end
    checkOutput("refill_full", 32'(a_full), 1);
    applyStimulus(1, 1, 3'b011, 32'h500, 1, 0);
    checkOutput("pp_count", 32'(a_count), 4);
    checkOutput("pp_full",  32'(a_full), 1);
    checkOutput("pp_ovf",   32'(a_ovf), 0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain2_head", a_addr, 32'(k + 2) * 32'h100);
      applyStimulus(0, 0, 3'b000, 0, 1, 0);
    end
    checkOutput("drain2_empty", 32'(a_empty), 1);

    // Pop on an empty FIFO with a simultaneous push: the push is accepted
    // and the pop is rejected.
    applyStimulus(1, 0, 3'b001, 32'h600, 1, 0);
    checkOutput("udf_flag",  32'(a_udf), 1);
    checkOutput("udf_count", 32'(a_count), 1);
    checkOutput("udf_head",  a_addr, 32'h600);
    checkOutput("udf_write", 32'(a_write), 0);
    checkOutput("udf_burst", 32'(a_burst), 1);
    applyStimulus(0, 0, 3'b000, 0, 1, 0);
    checkOutput("udf_pop_empty", 32'(a_empty), 1);
    applyStimulus(0, 0, 3'b000, 0, 1, 1);
    checkOutput("set_wins_udf", 32'(a_udf), 1);
    applyStimulus(0, 0, 3'b000, 0, 0, 1);
    checkOutput("clr_udf", 32'(a_udf), 0);
    checkOutput("clr_ovf2", 32'(a_ovf), 0);

    // Reset in the middle of operation, with an error pending.
    applyStimulus(0, 0, 3'b000, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 3'b011, 32'hA0 + 32'(k) * 32'h10, 0, 0);
    end
    checkOutput("pre_rst_count", 32'(a_count), 3);
    checkOutput("pre_rst_udf",   32'(a_udf), 1);
    doReset();
    checkOutput("mid_rst_count", 32'(a_count), 0);
    checkOutput("mid_rst_empty", 32'(a_empty), 1);
    checkOutput("mid_rst_valid", 32'(a_valid), 0);
    checkOutput("mid_rst_udf",   32'(a_udf), 0);
    checkOutput("mid_rst_addr",  a_addr, 0);
    applyStimulus(1, 1, 3'b011, 32'hD0, 0, 0);
    checkOutput("post_rst_count", 32'(a_count), 1);
    checkOutput("post_rst_head",  a_addr, 32'hD0);
    applyStimulus(0, 0, 3'b000, 0, 1, 0);
    checkOutput("post_rst_empty", 32'(a_empty), 1);

    // Registered-read instance: eight pushes, then one pop per cycle.
    doReset();
    checkOutput("b_rst_valid", 32'(b_valid), 0);
    checkOutput("b_rst_addr",  b_addr, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 1, 3'b011, 32'h1000 + 32'(k) * 32'h10, 0, 0);
      checkOutput("b_fill_valid", 32'(b_valid), 0);
    end
    checkOutput("b_fill_count", 32'(b_count), 8);
    checkOutput("b_fill_full",  32'(b_full), 1);
    checkOutput("b_fill_afull", 32'(b_afull), 1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 3'b000, 0, 1, 0);
      checkOutput("b_pop_valid", 32'(b_valid), 1);
      checkOutput("b_pop_addr",  b_addr, 32'h1000 + 32'(k) * 32'h10);
      checkOutput("b_pop_count", 32'(b_count), 32'(7 - k));
    end
    checkOutput("b_drain_empty", 32'(b_empty), 1);
    applyStimulus(0, 0, 3'b000, 0, 0, 0);
    checkOutput("b_idle_valid", 32'(b_valid), 0);
    checkOutput("b_hold_addr",  b_addr, 32'h1070);
    applyStimulus(0, 0, 3'b000, 0, 1, 0);
    checkOutput("b_rej_valid", 32'(b_valid), 0);
    checkOutput("b_rej_udf",   32'(b_udf), 1);
    checkOutput("b_rej_addr",  b_addr, 32'h1070);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_master_cmd_fifo.md
Name: ahb_master_cmd_fifo

Overview:
- Parametrised command FIFO between the user command port and the AHB master address-phase engine.
- Each entry holds one command: write flag, HBURST type, HSIZE and start address.
- Generalises the fixed 4-entry command buffer with:
  - configurable depth,
  - first-word-fall-through (FWFT) or registered read mode,
  - occupancy count and almost-full flag,
  - sticky overflow/underflow error flags.

Parameters:
- ADDR_WIDTH, 32, width of the command address field.
- DEPTH_LOG2, 2, log2 of the entry count (DEPTH = 2**DEPTH_LOG2); legal range 1..8.
- AFULL_LEVEL, 3, o_fifo_afull asserts when count >= AFULL_LEVEL; legal range 1..DEPTH.
- FWFT, 1, 1 = head entry visible on outputs without a pop; 0 = registered read with one-cycle latency.

Ports:
- i_clk  in  1  clock, all logic rising-edge.
- i_rstn  in  1  synchronous, active-low reset.
- i_wfifo_en  in  1  push strobe.
- i_wfifo_write  in  1  command direction, 1 = write.
- i_wfifo_user_burst_type  in  3  HBURST encoding.
- i_wfifo_user_size  in  3  HSIZE encoding.
- i_wfifo_user_addr  in  ADDR_WIDTH  start address.
- i_rfifo_en  in  1  pop strobe.
- i_err_clr  in  1  clears sticky error flags.
- o_rfifo_write  out  1  head/read command direction.
- o_rfifo_user_burst_type  out  3  head/read HBURST.
- o_rfifo_user_size  out  3  head/read HSIZE.
- o_rfifo_user_addr  out  ADDR_WIDTH  head/read address.
- o_rfifo_valid  out  1  read data valid.
- o_fifo_full  out  1  count == DEPTH.
- o_fifo_empty  out  1  count == 0.
- o_fifo_afull  out  1  count >= AFULL_LEVEL.
- o_fifo_count  out  DEPTH_LOG2+1  current occupancy.
- o_ovf_err  out  1  sticky: push while full without a same-cycle pop.
- o_udf_err  out  1  sticky: pop while empty.

Behaviour:
- Reset: synchronous on the rising edge of i_clk while i_rstn=0; no asynchronous path.
  - Pointers and count go to 0; empty=1; full=0; afull=0; valid=0; both error flags 0; all o_rfifo_* data outputs 0.
  - Storage array is not reset.
  - Reset mid-operation discards every stored entry; the first push after reset lands in slot 0.
- Pointers: write and read pointers are DEPTH_LOG2+1 bits.
  - Slot index is the low DEPTH_LOG2 bits; the MSB is the wrap bit.
  - Full = index equal and wrap bits differ; empty = pointers equal. Both flags are registered.
  - Pointers wrap naturally modulo 2*DEPTH.
- Push is accepted when i_wfifo_en=1 and (not full, or pop accepted in the same cycle).
  - The entry is written at the write pointer; the write pointer increments.
- Pop is accepted when i_rfifo_en=1 and not empty; the read pointer increments.
- Count: push only → +1; pop only → −1; both or neither → unchanged. full, empty and afull update on the same edge as the count.
- Rejected push (full, no pop): storage and pointers unchanged; o_ovf_err set.
- Pop when empty: pointers unchanged; o_udf_err set.
  - A same-cycle push into an empty FIFO is still accepted.
  - A same-cycle pop is not: an empty FIFO never bypasses input to output.
- Error flags: i_err_clr=1 clears both flags; if a new error occurs in the same cycle, set wins.
- FWFT=1:
  - o_rfifo_* show the entry at the read pointer; o_rfifo_valid = ~o_fifo_empty.
  - A pushed entry becomes visible one cycle after the push edge, when empty deasserts.
  - Pop presents the next entry in the following cycle.
- FWFT=0:
  - An accepted pop registers the head entry into o_rfifo_* on the pop edge; o_rfifo_valid pulses high for exactly that one following cycle.
  - o_rfifo_* hold their value until the next accepted pop.
  - A rejected pop leaves valid low.
- Ordering: strict FIFO, with no reordering or dropping of accepted entries.

Test Plan:
- Reset then push 4 commands (addr 0x100, 0x200, 0x300, 0x400; write=1; burst=3'b011) at DEPTH=4 → count 1..4; afull at count 3; full after the 4th push; FWFT head shows 0x100.
- Full FIFO, push addr 0x500 with no pop → entry dropped; o_ovf_err=1; count stays 4; draining yields 0x100, 0x200, 0x300, 0x400 only.
- Full FIFO, simultaneous push 0x500 and pop → count stays 4; full stays 1; no ovf error; drain order 0x200, 0x300, 0x400, 0x500 (exercises pointer wrap).
- Empty FIFO, pop with a simultaneous push of 0x600 → o_udf_err=1; count=1; 0x600 is read on the next pop; i_err_clr clears both flags the following cycle.
- FWFT=0, DEPTH_LOG2=3: push 8 entries, pop one per cycle → valid pulses 8 cycles each one cycle after its pop; data in order; empty after the 8th pop.
- Assert i_rstn=0 for one cycle with count=3 → next cycle count=0, empty=1, valid=0, errors=0; subsequent push/pop behaves as from cold reset.
